permutation_ctrl: RTL and testbench

- Sequencer FSM that drives the ASCON permutation datapath control interface: the `select_i`, `enable_i` and `round_i` inputs of `permutation_v1`.
- On a start request it runs either p^a (12 rounds) or p^b (6 rounds).
  - It loads the external state on the first round.
  - It feeds back the registered state on every later round.
  - It signals completion with a one-cycle `done_o` pulse.
- Sits between the top-level ASCON128 mode FSM (initiator) and the permutation datapath (responder).

---
 rtl/permutation_ctrl_pkg.sv | 22 ++
 rtl/permutation_ctrl_round_counter.sv | 46 ++++
 rtl/permutation_ctrl.sv | 125 ++++++++++++
 tb/tb_permutation_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/permutation_ctrl_pkg.sv
// permutation_ctrl_pkg
// Shared types and constants for the ASCON permutation round sequencer.
//   type_perm_fsm  : sequencer state encoding (IDLE, RUN, DONE)
//   NB_ROUNDS_MAX  : largest round count; round constants are indexed from
//                    NB_ROUNDS_MAX - N so that shorter permutations use the
//                    tail of the constant table
//   ROUNDS_PA/PB   : default round counts for p^a and p^b
//   CNT_W          : width of the round counter / round index
package permutation_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_perm_fsm;

  localparam int unsigned NB_ROUNDS_MAX = 12;
  localparam int unsigned ROUNDS_PA     = 12;
  localparam int unsigned ROUNDS_PB     = 6;
  localparam int unsigned CNT_W         = 4;

endpackage : permutation_ctrl_pkg

// File: rtl/permutation_ctrl_round_counter.sv
// round_counter
// 4-bit round counter for the permutation sequencer.
//   clk        : clock, rising edge
//   srst       : synchronous active-high reset (counter -> 0)
//   load_i     : load load_val_i (wins over inc_i)
//   inc_i      : increment counter by one
//   load_val_i : value loaded on load_i
//   n_i        : latched round count N of the current permutation
//   k_o        : current round number k
//   last_o     : terminal flag, k == N-1
module round_counter
  import permutation_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] k_o,
  output logic             last_o
);

  logic [CNT_W-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (load_i) begin
      k_d = load_val_i;
    end else if (inc_i) begin
      k_d = k_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k_o    = k_q;
  assign last_o = (k_q == (n_i - CNT_W'(1)));

endmodule : round_counter

// File: rtl/permutation_ctrl.sv
// permutation_ctrl
// Sequencer driving the select/enable/round control of the ASCON permutation
// datapath. Runs p^a (ROUNDS_A rounds) or p^b (ROUNDS_B rounds) on request.
//   clock_i  : clock, rising edge
//   reset_i  : synchronous active-high reset
//   start_i  : start request, accepted when ready_o=1
//   mode_i   : 0 = p^a, 1 = p^b; sampled with an accepted start_i
//   ready_o  : a start can be accepted this cycle (IDLE or DONE)
//   busy_o   : rounds in progress
//   select_o : datapath mux, 1 = external state (first round only)
//   enable_o : datapath register enable
//   round_o  : round constant index 0..11
//   done_o   : one-cycle pulse, datapath holds the final state
// All outputs are decoded from registered state only.
module permutation_ctrl
  import permutation_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS_A = ROUNDS_PA,
  parameter int unsigned ROUNDS_B = ROUNDS_PB
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             mode_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             select_o,
  output logic             enable_o,
  output logic [CNT_W-1:0] round_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] N_A   = CNT_W'(ROUNDS_A);
  localparam logic [CNT_W-1:0] N_B   = CNT_W'(ROUNDS_B);
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(NB_ROUNDS_MAX);

  type_perm_fsm     state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             cnt_load;
  logic             cnt_inc;
  logic             cnt_last;
  logic [CNT_W-1:0] k;

  round_counter u_round_counter (
    .clk        (clock_i),
    .srst       (reset_i),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .load_val_i ('0),
    .n_i        (n_q),
    .k_o        (k),
    .last_o     (cnt_last)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so back-to-back permutations
        // need no IDLE cycle in between.
        if (start_i) begin
          n_d      = mode_i ? N_B : N_A;
          cnt_load = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      n_q     <= N_A;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Output decode
  always_comb begin
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    select_o = 1'b0;
    enable_o = 1'b0;
    round_o  = '0;
    done_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
      end
      RUN: begin
        busy_o   = 1'b1;
        enable_o = 1'b1;
        select_o = (k == '0);
        // Shorter permutations use the last N round constants.
        round_o  = N_MAX - n_q + k;
      end
      DONE: begin
        ready_o = 1'b1;
        done_o  = 1'b1;
      end
      default: begin
        ready_o = 1'b1;
      end
    endcase
  end

endmodule : permutation_ctrl

// File: tb/tb_permutation_ctrl.sv
// tb_permutation_ctrl
// Scoreboard bench: each accepted start pushes the expected per-cycle
// output sequence; every cycle pops one entry (or expects idle outputs
// when nothing is pending) and compares it against the DUT.
module tb_permutation_ctrl;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       sel;
    logic       en;
    logic [3:0] round;
    logic       done;
  } obs_t;

  localparam obs_t IDLE_OBS = '{ready: 1'b1, busy: 1'b0, sel: 1'b0, en: 1'b0,
                                round: 4'd0, done: 1'b0};
  localparam obs_t DONE_OBS = '{ready: 1'b1, busy: 1'b0, sel: 1'b0, en: 1'b0,
                                round: 4'd0, done: 1'b1};

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i  = 1'b0;
  logic       ready_o;
  logic       busy_o;
  logic       select_o;
  logic       enable_o;
  logic [3:0] round_o;
  logic       done_o;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  permutation_ctrl #(
    .ROUNDS_A (12),
    .ROUNDS_B (6)
  ) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .select_o (select_o),
    .enable_o (enable_o),
    .round_o  (round_o),
    .done_o   (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b busy=%b sel=%b en=%b rnd=%0d done=%b, want rdy=%b busy=%b sel=%b en=%b rnd=%0d done=%b",
               tag, got.ready, got.busy, got.sel, got.en, got.round, got.done,
               exp.ready, exp.busy, exp.sel, exp.en, exp.round, exp.done);
    end
  endtask

  // Expected sequence for an N-round permutation: N RUN cycles then DONE.
  task automatic push_run(input int n);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      e.ready = 1'b0;
      e.busy  = 1'b1;
      e.sel   = (k == 0);
      e.en    = 1'b1;
      e.round = 4'(12 - n + k);
      e.done  = 1'b0;
      exp_q.push_back(e);
    end
    exp_q.push_back(DONE_OBS);
  endtask

  // Drive inputs for one cycle, let the edge pass, then compare.
  task automatic step(input logic s, input logic m, input logic r, input string tag);
    obs_t got;
    obs_t exp;
    start_i = s;
    mode_i  = m;
    reset_i = r;
    @(posedge clock_i);
    #1;
    cyc++;
    got = '{ready: ready_o, busy: busy_o, sel: select_o, en: enable_o,
            round: round_o, done: done_o};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OBS;
    chk($sformatf("%s_c%0d", tag, cyc), got, exp);
    if (done_o) $display("[TB] cycle %0d: done pulse (%s)", cyc, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with start asserted: reset must win.
    step(1'b1, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, "idle");

    // p^a single run
    $display("[TB] start p^a");
    push_run(12);
    step(1'b1, 1'b0, 1'b0, "pa");
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, "pa");

    // p^b single run
    $display("[TB] start p^b");
    push_run(6);
    step(1'b1, 1'b1, 1'b0, "pb");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, "pb");

    // p^a with a start pulse (mode=1) during RUN cycle 3: ignored
    $display("[TB] start p^a, stray start in run cycle 3");
    push_run(12);
    step(1'b1, 1'b0, 1'b0, "ign");
    step(1'b0, 1'b0, 1'b0, "ign");
    step(1'b0, 1'b0, 1'b0, "ign");
    step(1'b1, 1'b1, 1'b0, "ign");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, "ign");

    // p^a then p^b started in the DONE cycle
    $display("[TB] start p^a, then p^b back-to-back");
    push_run(12);
    step(1'b1, 1'b0, 1'b0, "b2b");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, "b2b");
    push_run(6);
    step(1'b1, 1'b1, 1'b0, "b2b");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, "b2b");

    // Reset during RUN cycle 5 of p^a: abort, no done pulse afterwards
    $display("[TB] start p^a, reset in run cycle 5");
    push_run(12);
    step(1'b1, 1'b0, 1'b0, "abort");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "abort");
    exp_q.delete();
    step(1'b0, 1'b0, 1'b1, "abort_rst");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, "abort_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_permutation_ctrl
